// File: rtl/seg7_pkg.sv
// Shared seven-segment constants (active-low, bit0=a .. bit6=g) and code values
// used by both the capture path and the existing encoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  // Legal digit enable: exactly one active-low bit.
  function automatic logic an_legal(input logic [3:0] an_n);
    logic [3:0] en;
    en = ~an_n;
    return (en != '0) && ((en & (en - 4'd1)) == '0);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern to digit-code decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] code,
  output logic       err
);

  always_comb begin
    code = CODE_ERR;
    err  = 1'b1;
    case (seg_n)
      SEG_0:     begin code = 4'h0;       err = 1'b0; end
      SEG_1:     begin code = 4'h1;       err = 1'b0; end
      SEG_2:     begin code = 4'h2;       err = 1'b0; end
      SEG_3:     begin code = 4'h3;       err = 1'b0; end
      SEG_4:     begin code = 4'h4;       err = 1'b0; end
      SEG_5:     begin code = 4'h5;       err = 1'b0; end
      SEG_6:     begin code = 4'h6;       err = 1'b0; end
      SEG_7:     begin code = 4'h7;       err = 1'b0; end
      SEG_8:     begin code = 4'h8;       err = 1'b0; end
      SEG_9:     begin code = 4'h9;       err = 1'b0; end
      SEG_BLANK: begin code = CODE_BLANK; err = 1'b0; end
      default:   begin code = CODE_ERR;   err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Captures a multiplexed seven-segment display: debounces each observed
// {an_n, dp_n, seg_n} pattern, decodes it and reports complete frames.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_n,
  input  logic        dp_n,
  input  logic [3:0]  an_n,
  output logic [15:0] digits,
  output logic [3:0]  digit_err,
  output logic [3:0]  dp_seen,
  output logic        frame_valid
);

  localparam logic       SETTLING = 1'b0;
  localparam logic       LOCKED   = 1'b1;
  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);

  logic [11:0] live;
  logic [11:0] samp;
  logic [7:0]  cnt;
  logic [3:0]  mask;
  logic        lock_state;
  logic        same;
  logic        accept;
  logic        legal;
  logic [3:0]  sel;
  logic [3:0]  acc_bits;
  logic [3:0]  dec_code;
  logic        dec_err;

  assign live       = {an_n, dp_n, seg_n};
  assign same       = (live == samp);
  assign lock_state = (cnt == CNT_MAX) ? LOCKED : SETTLING;
  // Fires only on the CNT_MAX-1 -> CNT_MAX transition, so a held pattern is taken once.
  assign accept     = same && (cnt == CNT_MAX - 8'd1);
  assign legal      = an_legal(samp[11:8]);
  assign sel        = ~samp[11:8];
  assign acc_bits   = (accept && legal) ? sel : '0;

  seg7_decode u_decode (
    .seg_n (samp[6:0]),
    .code  (dec_code),
    .err   (dec_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      samp        <= '1;
      cnt         <= '0;
      mask        <= '0;
      digits      <= '1;
      digit_err   <= '0;
      dp_seen     <= '0;
      frame_valid <= 1'b0;
    end else begin
      samp <= live;
      if (!same)
        cnt <= '0;
      else if (lock_state == SETTLING)
        cnt <= cnt + 8'd1;

      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_bits[i]) begin
          digits[4*i +: 4] <= dec_code;
          digit_err[i]     <= dec_err;
          dp_seen[i]       <= ~samp[7];
        end
      end

      // A full mask pulses frame_valid and restarts from whatever is accepted on this edge.
      if (mask == '1) begin
        frame_valid <= 1'b1;
        mask        <= acc_bits;
      end else begin
        frame_valid <= 1'b0;
        mask        <= mask | acc_bits;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed self-checking bench for seg7_capture with STABLE_CYCLES=4.
module tb_seg7_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic [3:0]  dp_seen;
  logic        frame_valid;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  seg7_capture #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .an_n        (an_n),
    .digits      (digits),
    .digit_err   (digit_err),
    .dp_seen     (dp_seen),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit after the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] an, input logic dp, input logic [6:0] seg);
    an_n  = an;
    dp_n  = dp;
    seg_n = seg;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0011000;
  localparam logic [6:0] PB = 7'b1111111;

  initial begin
    logic [6:0] pats [4];
    pats[0] = P1; pats[1] = P2; pats[2] = P3; pats[3] = P4;

    drive(4'b1111, 1'b1, PB);
    do_reset();
    check("rst_digits", digits, 16'hFFFF);
    check("rst_err", {12'h0, digit_err}, 16'h0);
    check("rst_dp", {12'h0, dp_seen}, 16'h0);
    check("rst_fv", {15'h0, frame_valid}, 16'h0);

    // Single digit held 10 cycles: accepted on the 4th edge after first sample.
    drive(4'b1110, 1'b1, P3);
    step(4);
    check("s1_before", digits, 16'hFFFF);
    step(1);
    check("s1_accept", digits, 16'hFFF3);
    step(5);
    check("s1_held", digits, 16'hFFF3);
    check("s1_fv", {15'h0, frame_valid}, 16'h0);

    // Four digits, 6 cycles each; frame_valid one cycle after the last acceptance.
    for (int d = 0; d < 4; d++) begin
      drive(~(4'b0001 << d), 1'b1, pats[d]);
      step(5);
      check($sformatf("s2_d%0d", d), {12'h0, digits[4*d +: 4]}, 16'(d + 1));
      check($sformatf("s2_fv_acc%0d", d), {15'h0, frame_valid}, 16'h0);
      step(1);
      check($sformatf("s2_fv_next%0d", d), {15'h0, frame_valid}, (d == 3) ? 16'h1 : 16'h0);
    end
    check("s2_digits", digits, 16'h4321);
    step(1);
    check("s2_fv_drop", {15'h0, frame_valid}, 16'h0);

    // Toggling every 3 cycles never settles.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(4'b1110, 1'b1, (k % 2 == 0) ? P1 : P2);
      step(3);
    end
    check("s3_digits", digits, 16'hFFFF);
    check("s3_fv", {15'h0, frame_valid}, 16'h0);

    // Illegal pattern on digit 2 with dp lit, then a legal 5 clears the error.
    drive(4'b1011, 1'b0, 7'b1010101);
    step(5);
    check("s4_err_digits", digits, 16'hFEFF);
    check("s4_err_flag", {12'h0, digit_err}, 16'h0004);
    check("s4_dp", {12'h0, dp_seen}, 16'h0004);
    drive(4'b1011, 1'b1, P5);
    step(5);
    check("s4_ok_digits", digits, 16'hF5FF);
    check("s4_ok_flag", {12'h0, digit_err}, 16'h0);
    check("s4_ok_dp", {12'h0, dp_seen}, 16'h0);

    // Two enables low: nothing updates and no mask bits are set.
    drive(4'b1100, 1'b1, P8);
    step(8);
    check("s5_digits", digits, 16'hF5FF);
    check("s5_err", {12'h0, digit_err}, 16'h0);
    // Mask holds only digit 2; adding digit 3 must not complete a frame.
    drive(4'b0111, 1'b1, P7);
    step(5);
    check("s5_d3", digits, 16'h75FF);
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("s5_nofv", {15'h0, frame_valid}, 16'h0);
    end
    drive(4'b1110, 1'b1, P8);
    step(5);
    check("s5_d0", digits, 16'h75F8);
    drive(4'b1101, 1'b1, PB);
    step(5);
    check("s5_blank", digits, 16'h75F8);
    check("s5_blank_err", {12'h0, digit_err}, 16'h0);
    check("s5_fv_acc", {15'h0, frame_valid}, 16'h0);
    step(1);
    check("s5_fv", {15'h0, frame_valid}, 16'h1);

    // Reset mid-interval discards the partial count.
    drive(4'b1110, 1'b1, P9);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("s6_rst", digits, 16'hFFFF);
    step(4);
    check("s6_before", digits, 16'hFFFF);
    check("s6_fv", {15'h0, frame_valid}, 16'h0);
    step(1);
    check("s6_accept", digits, 16'hFFF9);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 The block SHALL take parameter STABLE_CYCLES, default 4, range 2..255: consecutive identical samples required before a digit is accepted.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port seg_n, input, 7 bits: active-low segments, bit0=a through bit6=g.
REQ-005 The block SHALL have port dp_n, input, 1 bit: active-low decimal point.
REQ-006 The block SHALL have port an_n, input, 4 bits: active-low digit enables; a legal value has exactly one bit low.
REQ-007 The block SHALL have port digits, output, 16 bits: four 4-bit decoded codes; digit i is in bits [4i+3:4i].
REQ-008 The block SHALL have port digit_err, output, 4 bits: per digit, 1 if the last accepted pattern was illegal.
REQ-009 The block SHALL have port dp_seen, output, 4 bits: per digit, the decimal point state of the last accepted pattern (1 = lit).
REQ-010 The block SHALL have port frame_valid, output, 1 bit: one-cycle pulse when all four digits have been accepted since the last pulse.

Function
REQ-011 The block SHALL register {an_n, dp_n, seg_n} each cycle into a sample register (12 bits).
REQ-012 The stability counter SHALL behave as follows:
- Live input equal to the sample register: counter increments, saturating at STABLE_CYCLES.
- Live input different: counter loads 0.
REQ-013 Acceptance SHALL occur on the edge where the counter goes from STABLE_CYCLES-1 to STABLE_CYCLES. This is exactly once per stable interval and is the Nth edge after the edge that first samples the new pattern.
REQ-014 At acceptance with a legal an_n, the block SHALL update the selected digit's code, digit_err and dp_seen on that same edge.
REQ-015 At acceptance with an illegal an_n (zero or several bits low), the block SHALL update nothing and SHALL set no mask bit.
REQ-016 Decode SHALL map patterns to codes as follows (pattern -> code):
- 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4
- 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0011000->9
- 1111111 (blank) -> code F, err 0
- any other pattern -> code E, err 1
REQ-017 The block SHALL have two states per stability tracker: SETTLING (counter < STABLE_CYCLES) and LOCKED (counter saturated). Any input change returns the tracker to SETTLING.
REQ-018 A 4-bit accept mask SHALL set the bit for each legally accepted digit.
REQ-019 When an acceptance completes the mask, frame_valid SHALL pulse high on the following cycle, and the mask SHALL clear on the pulse edge.
REQ-020 An acceptance landing on the same edge as the mask clear SHALL set its bit in the freshly cleared mask and SHALL NOT be lost.
REQ-021 Re-accepting an already-masked digit SHALL update its outputs and leave the mask unchanged.
REQ-022 A pattern held indefinitely SHALL be accepted once only; the same pattern re-appearing after any change SHALL be accepted again.

Reset
REQ-023 With rst high at a rising edge, the block SHALL reset:
- sample register to all-ones
- counter to 0
- mask to 0
- digits to 16'hFFFF
- digit_err to 0
- dp_seen to 0
- frame_valid to 0
REQ-024 Reset asserted mid-interval SHALL discard the partial count; acceptance requires STABLE_CYCLES fresh edges after rst deasserts.

Structure
REQ-025 A shared package seg7_pkg SHALL hold the 7-bit segment constants for codes 0-9 and blank, plus the codes CODE_BLANK=4'hF and CODE_ERR=4'hE, shared with the existing encoder.
REQ-026 Pattern-to-code decode SHALL be a separate combinational sub-module, seg7_decode (seg_n -> code, err).

Verification
REQ-027 The bench SHALL cover these directed scenarios (STABLE_CYCLES=4):
- an_n=1110, seg_n=0110000 held 10 cycles -> digits[3:0]=3 on the 4th edge after first sample; exactly one acceptance.
- Drive 1,2,3,4 on digits 0-3, 6 cycles each -> digits=16'h4321 and frame_valid high for exactly one cycle, one cycle after the digit-3 acceptance.
- Pattern toggling every 3 cycles -> no acceptance; digits remain FFFF.
- seg_n=1010101 on digit 2 -> digits[11:8]=E, digit_err[2]=1; a following legal 5 -> digits[11:8]=5, err cleared.
- an_n=1100 held 8 cycles -> no output change and no mask bit.
- rst pulsed after 2 stable cycles, same input held -> acceptance 4 edges after rst deasserts; outputs at reset values until then.
